instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch stage that sits directly upstream of the instruction memory. It owns the PC and drives the memory's 14-bit word address and read enable. It captures the combinational read data in the same cycle and delivers {pc, instr, fault} to decode through a valid/ready handshake, buffered in a small FIFO. Branch/jump redirects from execute flush the buffer and restart fetch at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (must be word-aligned and below 2**(IMEM_AW+2))
IMEM_AW, 14, instruction memory word-address width; byte space = 2**(IMEM_AW+2)
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
imem_ren  output  1  high in cycles where a fetch is issued
imem_addr  output  IMEM_AW  word address = pc[IMEM_AW+1:2]
imem_data_i  input  32  instruction word, combinationally valid same cycle as imem_addr
redirect_valid  input  1  one-cycle pulse: discard buffered/in-flight fetches, restart at redirect_pc
redirect_pc  input  32  byte-address target
if_valid  output  1  head entry valid toward decode
if_ready  input  1  decode accepts head this cycle
if_pc  output  32  PC of head entry
if_instr  output  32  instruction of head entry
if_fault  output  1  head entry is a fetch fault (misaligned or out of range)

Behaviour:
- Reset (rst_n=0 at edge): pc<=RESET_PC, state<=FETCH, FIFO count<=0. Outputs: if_valid=0, if_pc=0, if_instr=0, if_fault=0, imem_ren=0. Reset overrides redirect and handshake in the same cycle; any buffered entries are discarded.
- States:
  - FETCH: normal sequential fetch.
  - HALT: a fault entry has been queued; no further fetches until redirect.
- Fault condition on current pc: pc[1:0]!=0, or pc[31:IMEM_AW+2]!=0.
- Fetch issue, in FETCH only, with redirect_valid=0: issue when (count<FIFO_DEPTH) or (if_valid & if_ready).
  - imem_ren=1; imem_addr=pc[IMEM_AW+1:2] (driven even when ren=0).
  - Issue pushes {pc, imem_data_i, 0}; pc<=pc+4, 32-bit wrap.
  - If pc faults: push {pc, 32'h0000_0013 (NOP), 1} instead, imem_ren=0, pc held, state<=HALT.
- Latency: pc presented in cycle N -> entry visible at if_* in cycle N+1 if the FIFO was empty. Sustained throughput is 1 instr/cycle with if_ready held high.
- Handshake:
  - Pop on if_valid&if_ready.
  - Head entry and if_* held stable while if_valid=1 and if_ready=0.
  - if_valid=(count!=0).
  - if_* are registered FIFO outputs, not combinational from imem_data_i.
- Full + pop in the same cycle: push and pop both occur, count unchanged.
- Empty: if_valid=0; if_pc/if_instr/if_fault hold last values (don't-care for checks).
- Redirect (highest priority after reset):
  - Same cycle: count<=0, no push, imem_ren=0, pc<=redirect_pc, state<=FETCH.
  - Any handshake completing that cycle is ignored by the decode contract.
  - Fetch at the new pc issues next cycle; if redirect_pc faults, the fault entry is pushed next cycle and the stage halts.
- A redirect during HALT exits HALT.
- Back-to-back redirects: the last one wins.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t packed struct {pc[31:0], instr[31:0], fault}
  - NOP_INSTR=32'h0000_0013
  - IMEM_AW default
  - fetch_state_e {FETCH, HALT}
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, full, empty, head.
  - Flush has priority over push.
- instr_fetch holds the PC, FSM, fault detect and the imem interface.

Test Plan:
- Sequential fetch: imem preloaded mem[0..3]=A,B,C,D; release rst_n, if_ready=1 -> if_valid rises 1 cycle after reset release; (pc,instr)=(0,A),(4,B),(8,C),(C,D) on consecutive cycles; imem_addr 0,1,2,3.
- Backpressure: if_ready=0 for 5 cycles after first valid -> FIFO fills to 2, imem_ren=0, head stays (0,A); raise if_ready -> A,B,C in order with no loss or duplication.
- Redirect flush: FIFO full, pulse redirect_valid with redirect_pc=0x40 -> next cycle if_valid=0 and imem_addr=0x10; following cycle head=(0x40, mem[0x10]); no stale entries appear.
- Misaligned redirect: redirect_pc=0x42 -> single entry (0x42, 0x00000013, fault=1); imem_ren stays 0 thereafter; redirect to 0x0 resumes normal fetch.
- Out of range: run sequentially to pc=0xFFFC -> entry (0xFFFC, mem[0x3FFF], 0), then (0x10000, NOP, fault=1), then HALT.
- Reset mid-operation: FIFO holding 2 entries with if_ready=0, assert rst_n=0 for 1 cycle together with redirect_valid=1 -> if_valid=0, pc restarts at RESET_PC, redirect ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_pkg                                                    |
// | Description : Shared types and constants for the instruction fetch stage:  |
// |               the buffered fetch entry, the fetch FSM state encoding and   |
// |               the NOP used to fill faulting fetch slots.                   |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  // Default instruction memory word-address width (16 KWords = 64 KiB).
  localparam int IMEM_AW_DEFAULT = 14;

  // RISC-V canonical NOP (addi x0, x0, 0), carried by fault entries.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_fifo                                                   |
// | Description : Small synchronous FIFO of fetch entries between the fetch    |
// |               logic and decode. Flush empties it and wins over push/pop.   |
// | Ports       : clk, rst_n       - clock, synchronous active-low reset       |
// |               push, din        - write an entry (ignored when full unless  |
// |                                  a pop happens in the same cycle)          |
// |               pop              - drop the head entry (ignored when empty)  |
// |               flush            - discard all entries                       |
// |               count/full/empty - occupancy                                 |
// |               head             - oldest entry, read from storage           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

  fetch_entry_t      r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = pop & ~empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      // Cleared so the head reads as all-zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch                                                  |
// | Description : Instruction fetch stage. Owns the PC, drives the instruction |
// |               memory address/read enable, captures the same-cycle read     |
// |               data and hands {pc, instr, fault} to decode through a small  |
// |               FIFO. Redirects flush the FIFO and restart fetch; a faulting |
// |               PC queues a single NOP fault entry and halts until redirect. |
// | Ports       : clk, rst_n          - clock, synchronous active-low reset    |
// |               imem_ren/imem_addr  - memory read enable / word address      |
// |               imem_data_i         - combinational read data                |
// |               redirect_valid/_pc  - restart pulse and byte target          |
// |               if_valid/if_ready   - handshake toward decode                |
// |               if_pc/instr/fault   - head entry toward decode               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_AW    = IMEM_AW_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_ren,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [31:0]         imem_data_i,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr,
  output logic                if_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic          w_pc_fault;
  logic          w_pop;
  logic          w_push;
  logic          w_flush;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;

  // Misaligned, or beyond the byte space covered by the instruction memory.
  assign w_pc_fault = (r_pc[1:0] != 2'b00) || ((r_pc >> (IMEM_AW + 2)) != 32'd0);

  assign w_pop     = ~w_empty & if_ready;
  assign imem_addr = r_pc[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_push             = 1'b0;
    w_flush            = 1'b0;
    imem_ren           = 1'b0;
    w_push_entry.pc    = r_pc;
    w_push_entry.instr = imem_data_i;
    w_push_entry.fault = 1'b0;

    if (!rst_n) begin
      // The registers take their reset values at this edge; issue nothing.
    end else if (redirect_valid) begin
      w_flush     = 1'b1;
      w_pc_nxt    = redirect_pc;
      w_state_nxt = FETCH;
    end else if ((r_state == FETCH) && (!w_full || w_pop)) begin
      w_push = 1'b1;
      if (w_pc_fault) begin
        // Memory is not read; the PC is frozen so decode sees the bad address.
        w_push_entry.instr = NOP_INSTR;
        w_push_entry.fault = 1'b1;
        w_state_nxt        = HALT;
      end else begin
        imem_ren = 1'b1;
        w_pc_nxt = r_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_push_entry),
    .pop   (w_pop),
    .flush (w_flush),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign if_valid = (w_count != '0);
  assign if_pc    = w_head.pc;
  assign if_instr = w_head.instr;
  assign if_fault = w_head.fault;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ren;
  logic [13:0] imem_addr;
  logic [31:0] imem_data_i;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  assign imem_data_i = mem[imem_addr];

  instr_fetch #(
    .RESET_PC   (RST_PC),
    .IMEM_AW    (14),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_ren       (imem_ren),
    .imem_addr      (imem_addr),
    .imem_data_i    (imem_data_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (queue of decode-visible entries) ------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc   = RST_PC;
  bit          m_halt = 0;
  bit          m_live = 0;

  function automatic bit m_bad(input logic [31:0] p);
    return (p[1:0] != 2'b00) || (p >= 32'h0001_0000);
  endfunction

  // Room exists if, after decode takes the head this cycle, fewer than 2 remain.
  function automatic bit m_room();
    int n = mq.size();
    if (if_ready && n > 0) n--;
    return n < 2;
  endfunction

  function automatic bit m_ren();
    return rst_n && !redirect_valid && !m_halt && m_room() && !m_bad(m_pc);
  endfunction

  task automatic model_cmp();
    bit          ok;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic        ef;
    ev  = (mq.size() != 0);
    epc = ev ? mq[0].pc    : 32'h0;
    ein = ev ? mq[0].instr : 32'h0;
    ef  = ev ? mq[0].fault : 1'b0;
    ok  = (if_valid === ev) && (imem_ren === m_ren()) && (imem_addr === m_pc[15:2]);
    if (ok && ev) ok = (if_pc === epc) && (if_instr === ein) && (if_fault === ef);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model t=%0t: got v=%0b ren=%0b addr=%h pc=%h instr=%h f=%0b, want v=%0b ren=%0b addr=%h pc=%h instr=%h f=%0b",
               $time, if_valid, imem_ren, imem_addr, if_pc, if_instr, if_fault,
               ev, m_ren(), m_pc[15:2], epc, ein, ef);
    end
  endtask

  task automatic model_step();
    bit can;
    if (!rst_n) begin
      mq.delete();
      m_pc   = RST_PC;
      m_halt = 0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc   = redirect_pc;
      m_halt = 0;
    end else begin
      can = m_room();
      if (if_ready && mq.size() > 0) void'(mq.pop_front());
      if (!m_halt && can) begin
        if (m_bad(m_pc)) begin
          mq.push_back('{m_pc, NOP_INSTR, 1'b1});
          m_halt = 1;
        end else begin
          mq.push_back('{m_pc, mem[m_pc[15:2]], 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Compare against the model, advance it, then cross one rising edge.
  task automatic tick();
    if (m_live) model_cmp();
    model_step();
    if (!rst_n) m_live = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
    rst_n          = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    if_ready       = rdy;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    bit          rst;
    bit          rdy;
    bit          v;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          ren;
    logic [13:0] addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit rdy, bit v, logic [31:0] pc, logic [31:0] ins,
                              bit ren, logic [13:0] a);
    vec_t x;
    x.rst = r; x.rdy = rdy; x.v = v; x.pc = pc; x.instr = ins; x.ren = ren; x.addr = a;
    return x;
  endfunction

  initial begin
    bit          r;
    bit          rv;
    bit          rdy;
    logic [31:0] rp;

    for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 | i;

    // Sequential fetch from reset.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 14'h0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 14'h0));
    tbl.push_back(mk(1, 1, 1, 32'h0, 32'hA500_0000, 1, 14'h1));
    tbl.push_back(mk(1, 1, 1, 32'h4, 32'hA500_0001, 1, 14'h2));
    tbl.push_back(mk(1, 1, 1, 32'h8, 32'hA500_0002, 1, 14'h3));
    tbl.push_back(mk(1, 1, 1, 32'hC, 32'hA500_0003, 1, 14'h4));
    // Reset again, then 5 cycles of backpressure after the first valid.
    tbl.push_back(mk(0, 0, 1, 32'h10, 32'hA500_0004, 0, 14'h5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 14'h0));
    tbl.push_back(mk(1, 0, 1, 32'h0, 32'hA500_0000, 1, 14'h1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 1, 32'h0, 32'hA500_0000, 0, 14'h2));
    tbl.push_back(mk(1, 1, 1, 32'h0, 32'hA500_0000, 1, 14'h2));
    tbl.push_back(mk(1, 1, 1, 32'h4, 32'hA500_0001, 1, 14'h3));
    tbl.push_back(mk(1, 1, 1, 32'h8, 32'hA500_0002, 1, 14'h4));
    tbl.push_back(mk(1, 1, 1, 32'hC, 32'hA500_0003, 1, 14'h5));

    // Initial reset, then reset-state outputs.
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk("reset if_valid", {31'h0, if_valid}, 32'h0);
    chk("reset if_pc",    if_pc,             32'h0);
    chk("reset if_instr", if_instr,          32'h0);
    chk("reset if_fault", {31'h0, if_fault}, 32'h0);
    chk("reset imem_ren", {31'h0, imem_ren}, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, 0, 0, tbl[i].rdy);
      chk($sformatf("vec%0d valid", i), {31'h0, if_valid}, {31'h0, tbl[i].v});
      chk($sformatf("vec%0d ren", i),   {31'h0, imem_ren}, {31'h0, tbl[i].ren});
      chk($sformatf("vec%0d addr", i),  {18'h0, imem_addr}, {18'h0, tbl[i].addr});
      if (tbl[i].v) begin
        chk($sformatf("vec%0d pc", i),    if_pc,    tbl[i].pc);
        chk($sformatf("vec%0d instr", i), if_instr, tbl[i].instr);
        chk($sformatf("vec%0d fault", i), {31'h0, if_fault}, 32'h0);
      end
      tick();
    end

    // Redirect flush with a full buffer.
    drive(0, 0, 0, 0); tick();
    drive(1, 0, 0, 0); tick(); tick();
    chk("full ren", {31'h0, imem_ren}, 32'h0);
    tick();
    drive(1, 1, 32'h40, 0);
    chk("redir ren", {31'h0, imem_ren}, 32'h0);
    tick();
    drive(1, 0, 0, 0);
    chk("redir valid", {31'h0, if_valid}, 32'h0);
    chk("redir addr", {18'h0, imem_addr}, 32'h10);
    chk("redir ren1", {31'h0, imem_ren}, 32'h1);
    tick();
    drive(1, 0, 0, 1);
    chk("redir head pc", if_pc, 32'h40);
    chk("redir head instr", if_instr, 32'hA500_0010);
    tick();
    chk("redir next pc", if_pc, 32'h44);

    // Misaligned redirect target.
    drive(1, 1, 32'h42, 1); tick();
    drive(1, 0, 0, 1);
    chk("mis valid0", {31'h0, if_valid}, 32'h0);
    chk("mis ren0",   {31'h0, imem_ren}, 32'h0);
    tick();
    chk("mis pc",    if_pc,    32'h42);
    chk("mis instr", if_instr, NOP_INSTR);
    chk("mis fault", {31'h0, if_fault}, 32'h1);
    chk("mis ren",   {31'h0, imem_ren}, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("halt valid", {31'h0, if_valid}, 32'h0);
      chk("halt ren",   {31'h0, imem_ren}, 32'h0);
      tick();
    end
    drive(1, 1, 32'h0, 1); tick();
    drive(1, 0, 0, 1);
    chk("resume ren",  {31'h0, imem_ren}, 32'h1);
    chk("resume addr", {18'h0, imem_addr}, 32'h0);
    tick();
    chk("resume instr", if_instr, 32'hA500_0000);

    // Out of range at the top of the memory.
    drive(1, 1, 32'hFFF8, 1); tick();
    drive(1, 0, 0, 1);
    chk("oor addr", {18'h0, imem_addr}, 32'h3FFE);
    tick();
    chk("oor pc0",    if_pc,    32'hFFF8);
    chk("oor instr0", if_instr, 32'hA500_3FFE);
    tick();
    chk("oor pc1",    if_pc,    32'hFFFC);
    chk("oor instr1", if_instr, 32'hA500_3FFF);
    chk("oor fault1", {31'h0, if_fault}, 32'h0);
    chk("oor ren1",   {31'h0, imem_ren}, 32'h0);
    tick();
    chk("oor pc2",    if_pc,    32'h0001_0000);
    chk("oor instr2", if_instr, NOP_INSTR);
    chk("oor fault2", {31'h0, if_fault}, 32'h1);
    tick();
    chk("oor halted", {31'h0, if_valid}, 32'h0);

    // Reset together with redirect while holding two entries.
    drive(1, 1, 32'h0, 0); tick();
    drive(1, 0, 0, 0); tick(); tick();
    chk("pre-rst valid", {31'h0, if_valid}, 32'h1);
    drive(0, 1, 32'h80, 0);
    chk("rst+redir ren", {31'h0, imem_ren}, 32'h0);
    tick();
    drive(1, 0, 0, 0);
    chk("post-rst valid", {31'h0, if_valid}, 32'h0);
    chk("post-rst addr",  {18'h0, imem_addr}, 32'h0);
    tick();
    chk("post-rst pc", if_pc, RST_PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(99) != 0);
      rv  = ($urandom_range(15) == 0);
      rdy = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0:       rp = 32'($urandom_range(16'hFFFF)) & 32'h0000_FFFC;
        1:       rp = 32'h0000_FFE0 + 32'($urandom_range(15)) * 32'd4;
        2:       rp = 32'($urandom_range(255));
        default: rp = $urandom;
      endcase
      drive(r, rv, rp, rdy);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
